// File: rtl/day_night_pkg.sv
// Shared definitions for the day/night sequencer and its consumers.
// Contents:
//    phase_t  - four-phase encoding (NIGHT=0, DAWN=1, DAY=2, DUSK=3)
//    FADE_MAX - fade value that means full day
package day_night_pkg;

   typedef enum logic [1:0] {
      PH_NIGHT = 2'd0,
      PH_DAWN  = 2'd1,
      PH_DAY   = 2'd2,
      PH_DUSK  = 2'd3
   } phase_t;

   localparam logic [7:0] FADE_MAX = 8'd255;

endpackage

// File: rtl/frame_step_div.sv
// Prescaler that turns frame updates into fade steps during the ramps.
// Ports:
//    clk_pix - pixel clock
//    rst     - synchronous active-high reset
//    en      - update cycle while in a ramp phase
//    clr     - clear the frame count (phase skip)
//    step    - high on the enabled update that completes STEP_FRAMES frames
module frame_step_div #(
   parameter int unsigned STEP_FRAMES = 2
) (
   input  logic clk_pix,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   logic [7:0] div_cnt;

   // Combinational so the fade can move on the same update that ends the count.
   assign step = en && (div_cnt == 8'(STEP_FRAMES - 1));

   always_ff @(posedge clk_pix) begin
      if (rst || clr) begin
         div_cnt <= 8'd0;
      end else if (en) begin
         div_cnt <= step ? 8'd0 : div_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/day_night_cycle_tt.sv
// Frame-synchronous day/night sequencer producing fade_level for the
// twilight background stage. All state moves only on frame_start, so the
// blend never changes mid-frame; a skip request is the only thing captured
// between frames.
// Ports:
//    clk_pix     - pixel clock
//    rst         - synchronous active-high reset
//    frame_start - one-cycle pulse at the start of each frame
//    pause       - freezes counters and fade on updates
//    skip        - request jump to the next phase at the next update
//    fade_level  - 0 = night, 255 = day (registered)
//    phase       - current phase (registered)
//    phase_tick  - one-cycle pulse after an update that changed phase
//
// state    | meaning
// ---------+----------------------------------------------
// PH_NIGHT | fade held at 0 for HOLD_FRAMES updates
// PH_DAWN  | fade rises by FADE_INC every STEP_FRAMES updates
// PH_DAY   | fade held at 255 for HOLD_FRAMES updates
// PH_DUSK  | fade falls by FADE_INC every STEP_FRAMES updates
module day_night_cycle_tt
   import day_night_pkg::*;
#(
   parameter int unsigned STEP_FRAMES = 2,
   parameter int unsigned HOLD_FRAMES = 600,
   parameter int unsigned FADE_INC    = 1
) (
   input  logic       clk_pix,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       pause,
   input  logic       skip,
   output logic [7:0] fade_level,
   output logic [1:0] phase,
   output logic       phase_tick
);

   phase_t             phase_q;
   logic        [15:0] hold_cnt;
   logic               skip_pend;
   logic               skip_eff;
   logic               ramp;
   logic               div_en;
   logic               div_clr;
   logic               step;
   logic         [8:0] sum9;
   logic signed  [8:0] diff9;
   logic         [7:0] fade_up;
   logic         [7:0] fade_dn;
   logic               hold_done;

   assign phase = phase_q;

   // A skip arriving on the update cycle itself is consumed by that update.
   assign skip_eff  = skip | skip_pend;
   assign ramp      = (phase_q == PH_DAWN) || (phase_q == PH_DUSK);
   assign div_en    = frame_start && !skip_eff && !pause && ramp;
   assign div_clr   = frame_start && skip_eff;
   assign hold_done = (hold_cnt == 16'(HOLD_FRAMES - 1));

   always_comb begin
      sum9    = {1'b0, fade_level} + 9'(FADE_INC);
      diff9   = $signed({1'b0, fade_level}) - $signed(9'(FADE_INC));
      fade_up = sum9[8] ? FADE_MAX : sum9[7:0];
      fade_dn = diff9[8] ? 8'd0 : diff9[7:0];
   end

   frame_step_div #(
      .STEP_FRAMES(STEP_FRAMES)
   ) u_step_div (
      .clk_pix (clk_pix),
      .rst     (rst),
      .en      (div_en),
      .clr     (div_clr),
      .step    (step)
   );

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         phase_q    <= PH_NIGHT;
         fade_level <= 8'd0;
         phase_tick <= 1'b0;
         hold_cnt   <= 16'd0;
         skip_pend  <= 1'b0;
      end else begin
         phase_tick <= 1'b0;
         if (!frame_start) begin
            if (skip) begin
               skip_pend <= 1'b1;
            end
         end else if (skip_eff) begin
            // Skip wins over pause; fade snaps to the level of the phase entered.
            skip_pend  <= 1'b0;
            hold_cnt   <= 16'd0;
            phase_tick <= 1'b1;
            unique case (phase_q)
               PH_NIGHT: phase_q <= PH_DAWN;
               PH_DAWN: begin
                  phase_q    <= PH_DAY;
                  fade_level <= FADE_MAX;
               end
               PH_DAY:   phase_q <= PH_DUSK;
               PH_DUSK: begin
                  phase_q    <= PH_NIGHT;
                  fade_level <= 8'd0;
               end
            endcase
         end else if (!pause) begin
            unique case (phase_q)
               PH_NIGHT, PH_DAY: begin
                  if (hold_done) begin
                     hold_cnt   <= 16'd0;
                     phase_tick <= 1'b1;
                     phase_q    <= (phase_q == PH_NIGHT) ? PH_DAWN : PH_DUSK;
                  end else begin
                     hold_cnt <= hold_cnt + 16'd1;
                  end
               end
               PH_DAWN: begin
                  if (step) begin
                     fade_level <= fade_up;
                     if (fade_up == FADE_MAX) begin
                        phase_q    <= PH_DAY;
                        hold_cnt   <= 16'd0;
                        phase_tick <= 1'b1;
                     end
                  end
               end
               PH_DUSK: begin
                  if (step) begin
                     fade_level <= fade_dn;
                     if (fade_dn == 8'd0) begin
                        phase_q    <= PH_NIGHT;
                        hold_cnt   <= 16'd0;
                        phase_tick <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_day_night_cycle_tt.sv
// Scoreboard bench for day_night_cycle_tt with STEP_FRAMES=2, HOLD_FRAMES=4,
// FADE_INC=64 and a nominal frame period of 10 clocks. Each update pushes
// its hand-computed outcome; the monitor checks outputs the cycle after.
module tb_day_night_cycle_tt;
   import day_night_pkg::*;

   typedef struct packed {
      logic [1:0] ph;
      logic [7:0] fade;
      logic       tick;
   } exp_t;

   logic       clk_pix = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic       pause = 1'b0;
   logic       skip = 1'b0;
   logic [7:0] fade_level;
   logic [1:0] phase;
   logic       phase_tick;

   logic       chk = 1'b0;
   logic       chk_d = 1'b0;
   logic       mon_en = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         upd_idx = 0;
   exp_t       sb[$];

   day_night_cycle_tt #(
      .STEP_FRAMES(2),
      .HOLD_FRAMES(4),
      .FADE_INC(64)
   ) dut (
      .clk_pix     (clk_pix),
      .rst         (rst),
      .frame_start (frame_start),
      .pause       (pause),
      .skip        (skip),
      .fade_level  (fade_level),
      .phase       (phase),
      .phase_tick  (phase_tick)
   );

   always #5 clk_pix = ~clk_pix;

   always @(posedge clk_pix) chk_d <= chk;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s (update %0d): got %0d, expected %0d", name, upd_idx, act, exp_v);
      end
   endtask

   // Monitor: compares on the cycle after each update; in between, phase_tick must stay low.
   always @(negedge clk_pix) begin
      exp_t e;
      if (chk_d) begin
         upd_idx++;
         if (sb.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            check("phase", int'(phase), int'(e.ph));
            check("fade_level", int'(fade_level), int'(e.fade));
            check("phase_tick", int'(phase_tick), int'(e.tick));
         end
      end else if (mon_en) begin
         check("phase_tick_idle", int'(phase_tick), 0);
      end
   end

   // Called at posedge+1; waits gap idle cycles, then issues one update cycle.
   task automatic frame(input int gap, input logic sk, input logic rs,
                        input logic [1:0] ph, input logic [7:0] f, input logic t);
      repeat (gap) @(posedge clk_pix);
      #1;
      frame_start = 1'b1;
      skip        = sk;
      rst         = rs;
      chk         = 1'b1;
      sb.push_back('{ph: ph, fade: f, tick: t});
      @(posedge clk_pix);
      #1;
      frame_start = 1'b0;
      skip        = 1'b0;
      rst         = 1'b0;
      chk         = 1'b0;
   endtask

   task automatic nf(input logic [1:0] ph, input logic [7:0] f, input logic t);
      frame(9, 1'b0, 1'b0, ph, f, t);
   endtask

   task automatic skip_pulse();
      skip = 1'b1;
      @(posedge clk_pix);
      #1;
      skip = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_pix);
      #1;
      frame(0, 1'b0, 1'b1, PH_NIGHT, 8'd0, 1'b0);
      mon_en = 1'b1;

      // Night hold, then dawn ramp to saturation
      repeat (3) nf(PH_NIGHT, 8'd0, 1'b0);
      nf(PH_DAWN, 8'd0, 1'b1);
      nf(PH_DAWN, 8'd0, 1'b0);
      nf(PH_DAWN, 8'd64, 1'b0);
      nf(PH_DAWN, 8'd64, 1'b0);
      nf(PH_DAWN, 8'd128, 1'b0);
      nf(PH_DAWN, 8'd128, 1'b0);
      nf(PH_DAWN, 8'd192, 1'b0);
      nf(PH_DAWN, 8'd192, 1'b0);
      nf(PH_DAY, 8'd255, 1'b1);

      // Day hold, then dusk ramp to zero
      repeat (3) nf(PH_DAY, 8'd255, 1'b0);
      nf(PH_DUSK, 8'd255, 1'b1);
      nf(PH_DUSK, 8'd255, 1'b0);
      nf(PH_DUSK, 8'd191, 1'b0);
      nf(PH_DUSK, 8'd191, 1'b0);
      nf(PH_DUSK, 8'd127, 1'b0);
      nf(PH_DUSK, 8'd127, 1'b0);
      nf(PH_DUSK, 8'd63, 1'b0);
      nf(PH_DUSK, 8'd63, 1'b0);
      nf(PH_NIGHT, 8'd0, 1'b1);

      // Second dawn up to 128, then pause for 20 frames
      repeat (3) nf(PH_NIGHT, 8'd0, 1'b0);
      nf(PH_DAWN, 8'd0, 1'b1);
      nf(PH_DAWN, 8'd0, 1'b0);
      nf(PH_DAWN, 8'd64, 1'b0);
      nf(PH_DAWN, 8'd64, 1'b0);
      nf(PH_DAWN, 8'd128, 1'b0);
      pause = 1'b1;
      repeat (20) nf(PH_DAWN, 8'd128, 1'b0);
      pause = 1'b0;
      nf(PH_DAWN, 8'd128, 1'b0);
      nf(PH_DAWN, 8'd192, 1'b0);

      // Skip while paused still advances; a plain paused update afterwards does not
      pause = 1'b1;
      skip_pulse();
      frame(8, 1'b0, 1'b0, PH_DAY, 8'd255, 1'b1);
      nf(PH_DAY, 8'd255, 1'b0);
      pause = 1'b0;
      repeat (3) nf(PH_DAY, 8'd255, 1'b0);
      nf(PH_DUSK, 8'd255, 1'b1);

      // Skip DUSK -> NIGHT forces fade to 0
      skip_pulse();
      frame(8, 1'b0, 1'b0, PH_NIGHT, 8'd0, 1'b1);
      repeat (3) nf(PH_NIGHT, 8'd0, 1'b0);
      nf(PH_DAWN, 8'd0, 1'b1);
      nf(PH_DAWN, 8'd0, 1'b0);
      nf(PH_DAWN, 8'd64, 1'b0);

      // Skip between frames at fade 64 in DAWN
      skip_pulse();
      frame(8, 1'b0, 1'b0, PH_DAY, 8'd255, 1'b1);

      // Skip coincident with frame_start is consumed by that update
      frame(9, 1'b1, 1'b0, PH_DUSK, 8'd255, 1'b1);
      nf(PH_DUSK, 8'd255, 1'b0);
      nf(PH_DUSK, 8'd191, 1'b0);
      nf(PH_DUSK, 8'd191, 1'b0);
      nf(PH_DUSK, 8'd127, 1'b0);

      // Reset together with frame_start and skip mid-dusk: no residual skip
      frame(9, 1'b1, 1'b1, PH_NIGHT, 8'd0, 1'b0);
      nf(PH_NIGHT, 8'd0, 1'b0);

      // Back-to-back updates each count
      frame(0, 1'b0, 1'b0, PH_NIGHT, 8'd0, 1'b0);
      frame(0, 1'b0, 1'b0, PH_NIGHT, 8'd0, 1'b0);
      frame(0, 1'b0, 1'b0, PH_DAWN, 8'd0, 1'b1);

      repeat (4) @(posedge clk_pix);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d pending, expected 0", sb.size());
      $fatal(1, "timeout");
   end

endmodule
